// File: rtl/timestamp_dr.sv
// Build-identification data register behind a virtual-JTAG instance: captures the
// build fields into a framed shift register, shifts them out LSB-first and checks the
// host's acknowledge frame on update. Define TIMESTAMP_DR_CRC_EN to append a CRC-8 byte.
module timestamp_dr #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] compile_num,
    input  logic [6:0] revision,
    input  logic [3:0] subrevision,
    input  logic [6:0] year,
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic       cdr,
    input  logic       sdr,
    input  logic       udr,
    input  logic       tdi,
    output logic       tdo,
    output logic [6:0] bit_count,
    output logic       frame_done,
    output logic       upd_valid,
    output logic [7:0] upd_data,
    output logic       len_err
);

`ifdef TIMESTAMP_DR_CRC_EN
    localparam int FRAME_LEN = 64;
`else
    localparam int FRAME_LEN = 56;
`endif
    localparam int         BASE_LEN    = 56;
    localparam logic [6:0] FRAME_LEN_C = 7'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADED   = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic [FRAME_LEN-1:0]   sr_q,        sr_d;
    logic [6:0]             bit_count_q, bit_count_d;
    logic                   upd_valid_q, upd_valid_d;
    logic [7:0]             upd_data_q,  upd_data_d;
    logic                   len_err_q,   len_err_d;

    logic [BASE_LEN-1:0]    base_frame;
    logic [FRAME_LEN-1:0]   capture_frame;

    assign base_frame = {2'b00, minute, hour, day, month, year,
                         subrevision, revision, compile_num, SYNC_BYTE};

`ifdef TIMESTAMP_DR_CRC_EN
    // Bitwise CRC-8 (poly 0x07, init 0), fed MSB-first from frame bit 55 down to 0.
    function automatic logic [7:0] crc8_07(input logic [BASE_LEN-1:0] d);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = BASE_LEN - 1; i >= 0; i--) begin
            fb  = crc[7] ^ d[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction

    assign capture_frame = {crc8_07(base_frame), base_frame};
`else
    assign capture_frame = base_frame;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_count_q <= '0;
            upd_valid_q <= 1'b0;
            upd_data_q  <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_count_q <= bit_count_d;
            upd_valid_q <= upd_valid_d;
            upd_data_q  <= upd_data_d;
            len_err_q   <= len_err_d;
        end
    end

    // Strobe priority is capture, then shift, then update; losers are dropped.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_count_d = bit_count_q;
        upd_valid_d = 1'b0;
        upd_data_d  = upd_data_q;
        len_err_d   = len_err_q;

        if (cdr) begin
            state_d     = LOADED;
            sr_d        = capture_frame;
            bit_count_d = '0;
        end else if (sdr) begin
            sr_d = {tdi, sr_q[FRAME_LEN-1:1]};
            unique case (state_q)
                LOADED, SHIFTING: begin
                    if (bit_count_q != FRAME_LEN_C) begin
                        bit_count_d = bit_count_q + 7'd1;
                    end
                    state_d = (bit_count_d == FRAME_LEN_C) ? DONE : SHIFTING;
                end
                // IDLE rotates without counting; DONE is already saturated.
                default: begin
                    state_d = state_q;
                end
            endcase
        end else if (udr) begin
            state_d = IDLE;
            if (bit_count_q == FRAME_LEN_C) begin
                upd_data_d  = sr_q[7:0];
                upd_valid_d = 1'b1;
            end else begin
                len_err_d = 1'b1;
            end
        end
    end

    assign tdo        = sr_q[0];
    assign bit_count  = bit_count_q;
    assign frame_done = (bit_count_q == FRAME_LEN_C);
    assign upd_valid  = upd_valid_q;
    assign upd_data   = upd_data_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_timestamp_dr.sv
// Scoreboard bench for timestamp_dr: capture, shift-out, acknowledge update,
// length errors, strobe priority and asynchronous reset.
module tb_timestamp_dr;

`ifdef TIMESTAMP_DR_CRC_EN
    localparam int FRAME_LEN = 64;
`else
    localparam int FRAME_LEN = 56;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] compile_num = '0;
    logic [6:0] revision = '0;
    logic [3:0] subrevision = '0;
    logic [6:0] year = '0;
    logic [3:0] month = '0;
    logic [4:0] day = '0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic       cdr = 1'b0;
    logic       sdr = 1'b0;
    logic       udr = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [6:0] bit_count;
    logic       frame_done;
    logic       upd_valid;
    logic [7:0] upd_data;
    logic       len_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sb_val[$];
    string       sb_tag[$];

    timestamp_dr #(.SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n),
        .compile_num(compile_num), .revision(revision), .subrevision(subrevision),
        .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
        .cdr(cdr), .sdr(sdr), .udr(udr), .tdi(tdi),
        .tdo(tdo), .bit_count(bit_count), .frame_done(frame_done),
        .upd_valid(upd_valid), .upd_data(upd_data), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] val);
        sb_tag.push_back(tag);
        sb_val.push_back(val);
    endtask

    task automatic sb_pop(input logic [63:0] got);
        if (sb_val.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got %0h with no expected entry", got);
        end else begin
            check_eq(sb_tag.pop_front(), got, sb_val.pop_front());
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read at that point too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_frame();
        logic [55:0] b;
        logic [7:0]  crc;
        b = {2'b00, minute, hour, day, month, year, subrevision, revision, compile_num, 8'hA5};
        crc = 8'h00;
        for (int k = 6; k >= 0; k--) begin
            crc = crc ^ b[k*8 +: 8];
            for (int j = 0; j < 8; j++) begin
                crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
            end
        end
`ifdef TIMESTAMP_DR_CRC_EN
        return {crc, b};
`else
        return {8'h00, b};
`endif
    endfunction

    task automatic capture();
        cdr = 1'b1;
        cycle();
        cdr = 1'b0;
    endtask

    task automatic shift_bits(input int n, input logic [63:0] pat, output logic [63:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            got[i] = tdo;
            sdr = 1'b1;
            tdi = pat[i];
            cycle();
        end
        sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic update();
        udr = 1'b1;
        cycle();
        udr = 1'b0;
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] pat;
        logic [63:0] exp_frame;

        // Reset state
        cycle();
        check_eq("rst_tdo", tdo, 0);
        check_eq("rst_bit_count", bit_count, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_upd_valid", upd_valid, 0);
        check_eq("rst_upd_data", upd_data, 0);
        check_eq("rst_len_err", len_err, 0);
        reset_n = 1'b1;
        cycle();

        compile_num = 8'h12; revision = 7'd63; subrevision = 4'd7; year = 7'd8;
        month = 4'd12; day = 5'd9; hour = 5'd13; minute = 6'd46;

        // Sync byte comes out first, LSB-first
        capture();
        sb_push("sync_byte", 64'hA5);
        shift_bits(8, 64'h0, got);
        sb_pop({56'h0, got[7:0]});
        check_eq("bc_after_8", bit_count, 8);
        check_eq("fd_after_8", frame_done, 0);

        // Full frame with acknowledge 0x3C
        capture();
        exp_frame = model_frame();
        sb_push("frame_fixed", exp_frame);
        pat = {$urandom, $urandom};
        pat[7:0] = 8'h3C;
        shift_bits(FRAME_LEN, pat, got);
        sb_pop(got);
        check_eq("fd_full", frame_done, 1);
        check_eq("bc_full", bit_count, FRAME_LEN);
`ifdef TIMESTAMP_DR_CRC_EN
        check_eq("crc_byte", got[63:56], exp_frame[63:56]);
`endif
        sb_push("upd_data_3c", 64'h3C);
        update();
        check_eq("upd_valid_pulse", upd_valid, 1);
        sb_pop(upd_data);
        check_eq("len_err_good", len_err, 0);
        cycle();
        check_eq("upd_valid_one_cycle", upd_valid, 0);

        // Shifting in IDLE does not count
        shift_bits(3, 64'h5, got);
        check_eq("bc_idle_shift", bit_count, FRAME_LEN);

        // Short frame -> length error, sticky
        capture();
        shift_bits(20, 64'hFFFFF, got);
        update();
        check_eq("short_no_valid", upd_valid, 0);
        check_eq("short_len_err", len_err, 1);
        check_eq("short_upd_data_kept", upd_data, 8'h3C);

        // Random fields, good frame with 0xC3 while len_err stays set
        compile_num = 8'($urandom); revision = 7'($urandom); subrevision = 4'($urandom);
        year = 7'($urandom); month = 4'($urandom); day = 5'($urandom);
        hour = 5'($urandom); minute = 6'($urandom);
        capture();
        sb_push("frame_random", model_frame());
        pat = {$urandom, $urandom};
        pat[7:0] = 8'hC3;
        shift_bits(FRAME_LEN, pat, got);
        sb_pop(got);
        sb_push("upd_data_c3", 64'hC3);
        update();
        check_eq("valid_after_err", upd_valid, 1);
        sb_pop(upd_data);
        check_eq("len_err_sticky", len_err, 1);

        // cdr and sdr together: capture wins
        tdi = 1'b0;
        cdr = 1'b1;
        sdr = 1'b1;
        cycle();
        cdr = 1'b0;
        sdr = 1'b0;
        check_eq("cdr_sdr_bc", bit_count, 0);
        check_eq("cdr_sdr_tdo", tdo, 1);

        // Asynchronous reset in the middle of shifting
        shift_bits(10, 64'h3FF, got);
        sdr = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_tdo", tdo, 0);
        check_eq("mid_rst_bc", bit_count, 0);
        check_eq("mid_rst_len_err", len_err, 0);
        check_eq("mid_rst_upd_data", upd_data, 0);
        sdr = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        update();
        check_eq("post_rst_udr_valid", upd_valid, 0);
        check_eq("post_rst_udr_len_err", len_err, 1);

        // sdr beats udr on the last shift, then one extra shift in DONE
        capture();
        pat = {$urandom, $urandom};
        shift_bits(FRAME_LEN - 1, pat, got);
        sdr = 1'b1;
        udr = 1'b1;
        tdi = pat[FRAME_LEN-1];
        cycle();
        sdr = 1'b0;
        udr = 1'b0;
        check_eq("sdr_udr_frame_done", frame_done, 1);
        check_eq("sdr_udr_no_valid", upd_valid, 0);
        shift_bits(1, 64'h1, got);
        check_eq("done_bc_saturated", bit_count, FRAME_LEN);
        sb_push("upd_data_rotated", {56'h0, pat[8:1]});
        update();
        check_eq("rotated_valid", upd_valid, 1);
        sb_pop(upd_data);

        if (sb_val.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_val.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
